slot_result_display: RTL and testbench
======================================

// Module: slot_result_display
// PURPOSE
//  Receiving end of the four-reel random digit generator. Samples randNum1..4 and stopInt.
//  Waits until the sequential reel stop has settled, then latches the four digits.
//  Scores the latched digits by their largest group of equal values.
//  Drives a multiplexed 4-digit seven-segment display: live digits while spinning,
//  latched digits after the result, blinking on a jackpot.
// PARAMETERS
//  SETTLE_CYCLES  48  cycles after stopInt is seen high before latching; must be >= 45 (generator finishes in 44)
//  SCAN_DIV       17  width of the refresh counter; its top 2 bits select the digit
//  BLINK_DIV      25  width of the blink counter; its MSB gates the anodes on a jackpot
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  stopInt      in   1  reel stop request: 1 = stopping or stopped, 0 = spinning
//  randNum1     in   4  reel 1 digit (leftmost, an[3])
//  randNum2     in   4  reel 2 digit (an[2])
//  randNum3     in   4  reel 3 digit (an[1])
//  randNum4     in   4  reel 4 digit (rightmost, an[0])
//  seg          out  7  {g,f,e,d,c,b,a}, active-low cathodes
//  an           out  4  active-low digit anodes, one-hot-low
//  result_valid out  1  high while a latched result is held
//  match_count  out  3  size of largest group of equal latched digits, 1..4; 0 when not valid
//  jackpot      out  1  high when match_count == 4 and result_valid is high
// BEHAVIOUR
//  Reset (reset=0, async, dominates everything):
//   - state=IDLE; all counters=0; latches=0
//   - seg=7'h7F; an=4'hF; result_valid=0; match_count=0; jackpot=0
//  FSM states: IDLE, SETTLE, LATCH, SHOW. stopInt is sampled on clk.
//   - IDLE: on stopInt=1 -> SETTLE with settle_cnt=0 (call this edge E0).
//   - SETTLE: settle_cnt++ each cycle; at settle_cnt==SETTLE_CYCLES-1 -> LATCH.
//   - LATCH: one cycle; capture randNum1..4; compute the score -> SHOW.
//   - SHOW: hold the result until stopInt=0.
//   - Abort: in SETTLE, LATCH or SHOW, stopInt=0 -> IDLE next edge. Abort beats every other transition.
//  Latency and result outputs:
//   - result_valid, match_count and jackpot are registered.
//   - They update at edge E0+SETTLE_CYCLES+1 and are stable for all of SHOW.
//   - They clear to 0 on the edge that enters IDLE.
//  Scoring:
//   - match_count = max over i of the count of j with d[j]==d[i]; range 1..4.
//   - A pair plus a different pair scores 2.
//   - Comparisons use the full 4 bits; values 10..15 compare like any other value.
//  Display:
//   - scan_cnt (SCAN_DIV bits) free-runs in all states and wraps at 2^SCAN_DIV.
//   - scan_cnt top 2 bits 0,1,2,3 select an = 1110,1101,1011,0111 (d4,d3,d2,d1).
//   - Digit source: live randNum in IDLE and SETTLE; latched digits in LATCH and SHOW.
//   - Glyphs 0..9 use standard decimal patterns, e.g. 1 -> 7'b1111001, 8 -> 7'b0000000.
//   - Values 10..15 show a dash: 7'b0111111.
//   - seg and an are registered, one cycle after scan_cnt.
//  Blink:
//   - blink_cnt (BLINK_DIV bits) counts only in SHOW; it is zeroed whenever SHOW is entered.
//   - In SHOW with jackpot=1 and blink_cnt MSB=1: an=4'hF and seg=7'h7F.
//  Input changes while in SHOW do not alter the display or the result outputs.
// TESTING (sim with SETTLE_CYCLES=48, SCAN_DIV=4, BLINK_DIV=6)
//  1 Digits 7,7,7,7 held; stopInt 0->1 at E0:
//    - result_valid=1, match_count=4, jackpot=1 exactly at E0+49.
//    - Display blanks for 32 of every 64 cycles.
//  2 Digits 3,5,3,9 -> match_count=2, jackpot=0; 2,2,6,6 -> 2; 4,4,4,0 -> 3; 1,2,3,4 -> 1. No blinking.
//  3 stopInt dropped 20 cycles into SETTLE:
//    - Returns to IDLE; result_valid stays 0.
//    - Re-raising stopInt gives result_valid exactly 49 cycles later.
//  4 IDLE, digits 1,2,3,12:
//    - an steps 1110,1101,1011,0111, each held 4 cycles.
//    - seg is dash, 3, 2, 1 in step (dash = 7'b0111111, 1 = 7'b1111001).
//  5 In SHOW, change randNum inputs -> seg and results unchanged; stopInt=0 -> next edge result_valid=0, match_count=0.
//  6 Drive reset=0 mid-SHOW between clock edges:
//    - Outputs go to reset values immediately, without a clock.
//    - After release, the FSM is in IDLE.

Source files
------------

// File: rtl/slot_result_display.sv
// Result end of the four-reel slot: waits for the reels to settle, latches and scores
// the digits, and drives a multiplexed 4-digit seven-segment display (blinks on a jackpot).
module slot_result_display #(
  parameter int SETTLE_CYCLES = 48,
  parameter int SCAN_DIV      = 17,
  parameter int BLINK_DIV     = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stopInt,
  input  logic [3:0] randNum1,
  input  logic [3:0] randNum2,
  input  logic [3:0] randNum3,
  input  logic [3:0] randNum4,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       result_valid,
  output logic [2:0] match_count,
  output logic       jackpot
);

  localparam int SW = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LATCH  = 2'd2,
    SHOW   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [SCAN_DIV-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_DIV-1:0] blink_cnt_q, blink_cnt_d;
  logic [15:0]          digits_q, digits_d;
  logic                 result_valid_q, result_valid_d;
  logic [2:0]           match_count_q, match_count_d;
  logic                 jackpot_q, jackpot_d;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;

  logic [15:0] live_digits;
  logic [15:0] src_digits;
  logic [1:0]  sel;
  logic [3:0]  cur_digit;
  logic [2:0]  score_w;
  logic        blank;

  // Largest group of equal digits; digits packed {d1,d2,d3,d4}.
  function automatic logic [2:0] score(input logic [15:0] d);
    logic [2:0] best;
    logic [2:0] cnt;
    best = 3'd1;
    for (int i = 0; i < 4; i++) begin
      cnt = 3'd0;
      for (int j = 0; j < 4; j++) begin
        cnt = cnt + {2'b00, (d[i*4 +: 4] == d[j*4 +: 4])};
      end
      if (cnt > best) best = cnt;
    end
    return best;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  assign live_digits = {randNum1, randNum2, randNum3, randNum4};
  assign score_w     = score(digits_q);

  // Next state; dropping stopInt wins over every other transition.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      IDLE: begin
        if (stopInt) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (!stopInt) begin
          state_d = IDLE;
        end else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = LATCH;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      LATCH: begin
        state_d = stopInt ? SHOW : IDLE;
      end
      SHOW: begin
        if (!stopInt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digits are captured on entry to LATCH so the display shows them during LATCH;
  // the score of those digits is registered on the LATCH -> SHOW edge.
  always_comb begin
    digits_d       = digits_q;
    result_valid_d = result_valid_q;
    match_count_d  = match_count_q;
    jackpot_d      = jackpot_q;
    if (state_q == SETTLE && state_d == LATCH) digits_d = live_digits;
    if (state_d == IDLE) begin
      result_valid_d = 1'b0;
      match_count_d  = 3'd0;
      jackpot_d      = 1'b0;
    end else if (state_q == LATCH && state_d == SHOW) begin
      result_valid_d = 1'b1;
      match_count_d  = score_w;
      jackpot_d      = (score_w == 3'd4);
    end
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    blink_cnt_d = (state_q == SHOW) ? blink_cnt_q + 1'b1 : '0;
    src_digits  = (state_q == LATCH || state_q == SHOW) ? digits_q : live_digits;
    sel         = scan_cnt_q[SCAN_DIV-1 -: 2];
    cur_digit   = src_digits[{sel, 2'b00} +: 4];
    blank       = (state_q == SHOW) && jackpot_q && blink_cnt_q[BLINK_DIV-1];
    seg_d       = blank ? 7'h7F : glyph(cur_digit);
    an_d        = blank ? 4'hF : ~(4'b0001 << sel);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      settle_cnt_q   <= '0;
      scan_cnt_q     <= '0;
      blink_cnt_q    <= '0;
      digits_q       <= '0;
      result_valid_q <= 1'b0;
      match_count_q  <= 3'd0;
      jackpot_q      <= 1'b0;
      seg_q          <= 7'h7F;
      an_q           <= 4'hF;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      scan_cnt_q     <= scan_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      digits_q       <= digits_d;
      result_valid_q <= result_valid_d;
      match_count_q  <= match_count_d;
      jackpot_q      <= jackpot_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
    end
  end

  assign seg          = seg_q;
  assign an           = an_q;
  assign result_valid = result_valid_q;
  assign match_count  = match_count_q;
  assign jackpot      = jackpot_q;

endmodule

// File: tb/tb_slot_result_display.sv
// Self-checking bench for slot_result_display: latency, scoring, scan order, blink,
// input freeze in SHOW, abort and asynchronous reset.
module tb_slot_result_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stop_int;
  logic [3:0] r1, r2, r3, r4;
  logic [6:0] seg;
  logic [3:0] an;
  logic       result_valid;
  logic [2:0] match_count;
  logic       jackpot;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  slot_result_display #(
    .SETTLE_CYCLES(48),
    .SCAN_DIV     (4),
    .BLINK_DIV    (6)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .stopInt     (stop_int),
    .randNum1    (r1),
    .randNum2    (r2),
    .randNum3    (r3),
    .randNum4    (r4),
    .seg         (seg),
    .an          (an),
    .result_valid(result_valid),
    .match_count (match_count),
    .jackpot     (jackpot)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  // Histogram-based score model.
  function automatic logic [2:0] model_score(input logic [3:0] a, b, c, d);
    int h[16];
    int best;
    for (int i = 0; i < 16; i++) h[i] = 0;
    h[a]++; h[b]++; h[c]++; h[d]++;
    best = 0;
    for (int i = 0; i < 16; i++) if (h[i] > best) best = h[i];
    return 3'(best);
  endfunction

  // Expected segment pattern for a given anode, from the four shown digits.
  function automatic logic [6:0] exp_seg(input logic [3:0] a_n, input logic [3:0] d1, d2, d3, d4);
    logic [6:0] g;
    case (a_n)
      4'b1110: g = glyph(d4);
      4'b1101: g = glyph(d3);
      4'b1011: g = glyph(d2);
      4'b0111: g = glyph(d1);
      default: g = 7'bxxxxxxx;
    endcase
    return g;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d);
    r1 = a; r2 = b; r3 = c; r4 = d;
  endtask

  // Raises stopInt, checks result_valid is low at E0+48 and the scored result at E0+49.
  task automatic run_round(input logic [3:0] a, b, c, d, input logic [2:0] exp_mc, input string name);
    logic [3:0] exp;
    logic [3:0] got;
    set_digits(a, b, c, d);
    exp_q.push_back({(exp_mc == 3'd4), exp_mc});
    stop_int = 1'b1;
    tick();  // E0
    for (int k = 1; k <= 49; k++) begin
      tick();
      if (k == 48) begin
        n_checks++;
        if (result_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early_valid: result_valid=%b at E0+48, required 0", name, result_valid);
        end
      end
    end
    exp = exp_q.pop_front();
    got = {jackpot, match_count};
    n_checks++;
    if (result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s valid: result_valid=%b at E0+49, required 1", name, result_valid);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s score: {jackpot,match_count}=%b, required %b", name, got, exp);
    end
  endtask

  task automatic drop_and_check(input string name);
    stop_int = 1'b0;
    tick();
    n_checks++;
    if (result_valid !== 1'b0 || match_count !== 3'd0 || jackpot !== 1'b0) begin
      n_fail++;
      $display("FAIL %s clear: rv=%b mc=%0d jp=%b, required 0 0 0", name, result_valid, match_count, jackpot);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    stop_int = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) tick();
    n_checks++;
    if (seg !== 7'h7F || an !== 4'hF || result_valid !== 1'b0 || match_count !== 3'd0 || jackpot !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: seg=%h an=%h rv=%b mc=%0d jp=%b, required 7f f 0 0 0",
               seg, an, result_valid, match_count, jackpot);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_jackpot();
    int blanks;
    int bad_seg;
    run_round(4'd7, 4'd7, 4'd7, 4'd7, 3'd4, "jackpot");
    blanks  = 0;
    bad_seg = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (an === 4'hF) begin
        blanks++;
        if (seg !== 7'h7F) bad_seg++;
      end else if (seg !== 7'b1111000) begin
        bad_seg++;
      end
    end
    n_checks++;
    if (blanks !== 64) begin
      n_fail++;
      $display("FAIL jackpot_blink: %0d blank cycles of 128, required 64", blanks);
    end
    n_checks++;
    if (bad_seg !== 0) begin
      n_fail++;
      $display("FAIL jackpot_seg: %0d bad seg samples, required 0", bad_seg);
    end
    drop_and_check("jackpot");
  endtask

  task automatic test_scores();
    logic [3:0] tab_d[4][4];
    logic [2:0] tab_mc[4];
    logic [3:0] a, b, c, d;
    int blanks;
    tab_d[0] = '{4'd3, 4'd5, 4'd3, 4'd9}; tab_mc[0] = 3'd2;
    tab_d[1] = '{4'd2, 4'd2, 4'd6, 4'd6}; tab_mc[1] = 3'd2;
    tab_d[2] = '{4'd4, 4'd4, 4'd4, 4'd0}; tab_mc[2] = 3'd3;
    tab_d[3] = '{4'd1, 4'd2, 4'd3, 4'd4}; tab_mc[3] = 3'd1;
    for (int t = 0; t < 4; t++) begin
      run_round(tab_d[t][0], tab_d[t][1], tab_d[t][2], tab_d[t][3], tab_mc[t], $sformatf("score%0d", t));
      blanks = 0;
      for (int i = 0; i < 70; i++) begin
        tick();
        if (an === 4'hF) blanks++;
      end
      n_checks++;
      if (blanks !== 0) begin
        n_fail++;
        $display("FAIL score%0d_noblink: %0d blank cycles, required 0", t, blanks);
      end
      drop_and_check($sformatf("score%0d", t));
    end
    // Random digits including 10..15, expected from the histogram model.
    for (int t = 0; t < 4; t++) begin
      a = 4'($urandom_range(10, 15));
      b = (t[0]) ? a : 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      d = (t[1]) ? a : 4'($urandom_range(10, 15));
      run_round(a, b, c, d, model_score(a, b, c, d), $sformatf("rand%0d", t));
      drop_and_check($sformatf("rand%0d", t));
    end
  endtask

  task automatic test_abort();
    int seen;
    set_digits(4'd1, 4'd1, 4'd2, 4'd3);
    stop_int = 1'b1;
    tick();  // E0
    repeat (20) tick();
    stop_int = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (result_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_valid: result_valid high %0d cycles after abort, required 0", seen);
    end
    run_round(4'd1, 4'd1, 4'd2, 4'd3, 3'd2, "after_abort");
    drop_and_check("after_abort");
  endtask

  task automatic test_scan();
    logic [3:0] an_s[32];
    logic [6:0] seg_s[32];
    int seg_err, seq_err, run_err, changes, run_len;
    logic [3:0] nxt;
    stop_int = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd12);
    repeat (3) tick();
    for (int i = 0; i < 32; i++) begin
      tick();
      an_s[i]  = an;
      seg_s[i] = seg;
    end
    seg_err = 0; seq_err = 0; run_err = 0; changes = 0; run_len = 0;
    for (int i = 0; i < 32; i++) begin
      if (seg_s[i] !== exp_seg(an_s[i], 4'd1, 4'd2, 4'd3, 4'd12)) seg_err++;
      if (i > 0) begin
        if (an_s[i] !== an_s[i-1]) begin
          case (an_s[i-1])
            4'b1110: nxt = 4'b1101;
            4'b1101: nxt = 4'b1011;
            4'b1011: nxt = 4'b0111;
            default: nxt = 4'b1110;
          endcase
          if (an_s[i] !== nxt) seq_err++;
          if (changes > 0 && run_len != 4) run_err++;
          changes++;
          run_len = 1;
        end else begin
          run_len++;
        end
      end
    end
    n_checks++;
    if (seg_err !== 0) begin
      n_fail++;
      $display("FAIL scan_seg: %0d seg samples wrong for their anode, required 0", seg_err);
    end
    n_checks++;
    if (seq_err !== 0) begin
      n_fail++;
      $display("FAIL scan_order: %0d out-of-order anode steps, required 0", seq_err);
    end
    n_checks++;
    if (run_err !== 0 || changes < 7) begin
      n_fail++;
      $display("FAIL scan_hold: %0d runs not 4 cycles, %0d steps, required 0 and >=7", run_err, changes);
    end
  endtask

  task automatic test_show_freeze();
    int err;
    run_round(4'd4, 4'd4, 4'd4, 4'd0, 3'd3, "freeze");
    err = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (seg !== exp_seg(an, 4'd4, 4'd4, 4'd4, 4'd0)) err++;
    end
    n_checks++;
    if (err !== 0) begin
      n_fail++;
      $display("FAIL freeze_show_seg: %0d wrong seg samples, required 0", err);
    end
    set_digits(4'd9, 4'd8, 4'd7, 4'd6);
    err = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (seg !== exp_seg(an, 4'd4, 4'd4, 4'd4, 4'd0)) err++;
    end
    n_checks++;
    if (err !== 0) begin
      n_fail++;
      $display("FAIL freeze_after_change: %0d seg samples followed new inputs, required 0", err);
    end
    n_checks++;
    if (result_valid !== 1'b1 || match_count !== 3'd3 || jackpot !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_result: rv=%b mc=%0d jp=%b, required 1 3 0", result_valid, match_count, jackpot);
    end
    drop_and_check("freeze");
  endtask

  task automatic test_async_reset();
    int err;
    run_round(4'd7, 4'd7, 4'd7, 4'd7, 3'd4, "pre_reset");
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (seg !== 7'h7F || an !== 4'hF || result_valid !== 1'b0 || match_count !== 3'd0 || jackpot !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: seg=%h an=%h rv=%b mc=%0d jp=%b, required 7f f 0 0 0",
               seg, an, result_valid, match_count, jackpot);
    end
    stop_int = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    repeat (3) tick();
    err = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (result_valid !== 1'b0) err++;
      if (seg !== exp_seg(an, 4'd5, 4'd6, 4'd7, 4'd8)) err++;
    end
    n_checks++;
    if (err !== 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: %0d samples not idle/live, required 0", err);
    end
    run_round(4'd5, 4'd6, 4'd7, 4'd8, 3'd1, "post_reset");
    drop_and_check("post_reset");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_jackpot();
    test_scores();
    test_abort();
    test_scan();
    test_show_freeze();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected results left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
